dcm_ps_responder: RTL and testbench

Responder side of the DCM variable phase-shift port (psen / psincdec / psdone), used in the ADC unit as a cycle-accurate stand-in for the DCM phase-shift logic. It lets the phase-shift controller and the ADC clock-alignment logic be exercised and verified without a hardware DCM. The block accepts single-cycle psen requests and tracks a signed phase-tap value with saturation. After a fixed latency it returns a one-cycle psdone, plus overflow and protocol-error status.

---
 rtl/dcm_ps_responder_if.sv | 32 +++
 rtl/dcm_ps_responder.sv | 112 +++++++++++
 tb/tb_dcm_ps_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dcm_ps_responder_if.sv
// rtl/dcm_ps_responder_if.sv - DCM variable phase-shift port bundle (psen/psincdec/psdone + status)
interface dcm_ps_responder_if #(
    parameter int PS_W = 9
) ();
    logic            psen;
    logic            psincdec;
    logic            psdone;
    logic [PS_W-1:0] ps_value;
    logic            ps_ovf;
    logic            busy;
    logic            ps_err;

    modport master (
        output psen,
        output psincdec,
        input  psdone,
        input  ps_value,
        input  ps_ovf,
        input  busy,
        input  ps_err
    );

    modport slave (
        input  psen,
        input  psincdec,
        output psdone,
        output ps_value,
        output ps_ovf,
        output busy,
        output ps_err
    );
endinterface

// File: rtl/dcm_ps_responder.sv
// rtl/dcm_ps_responder.sv - cycle-accurate DCM phase-shift responder with saturating tap value
module dcm_ps_responder #(
    parameter int PS_LATENCY = 8,
    parameter int PS_MAX     = 255,
    parameter int PS_W       = 9
) (
    input  logic               clk,
    input  logic               rst,
    dcm_ps_responder_if.slave  ps
);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0]       CNT_LOAD = CNT_W'(PS_LATENCY - 2);
    localparam logic signed [PS_W-1:0] MAX_S    = PS_W'(PS_MAX);
    localparam logic signed [PS_W-1:0] MIN_S    = -MAX_S;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dir_q, dir_d;
    logic signed [PS_W-1:0] val_q, val_d;
    logic                   ovf_q, ovf_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            val_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            val_q   <= val_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        val_d   = val_q;
        ovf_d   = ovf_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (ps.psen) begin
                    dir_d   = ps.psincdec;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (ps.psen) begin
                    err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    // Saturation is decided on the pre-update value so the tap never wraps
                    if (dir_q && (val_q < MAX_S)) begin
                        val_d = val_q + 1'b1;
                        ovf_d = 1'b0;
                    end else if (!dir_q && (val_q > MIN_S)) begin
                        val_d = val_q - 1'b1;
                        ovf_d = 1'b0;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (ps.psen) begin
                    dir_d   = ps.psincdec;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
    end

    assign ps.psdone   = done_q;
    assign ps.ps_value = val_q;
    assign ps.ps_ovf   = ovf_q;
    assign ps.busy     = busy_q;
    assign ps.ps_err   = err_q;
endmodule

// File: tb/tb_dcm_ps_responder.sv
// tb/tb_dcm_ps_responder.sv - scoreboard bench for dcm_ps_responder
module tb_dcm_ps_responder;
    localparam int L    = 8;
    localparam int PMAX = 255;
    localparam int W    = 9;

    logic clk;
    logic rst;
    int   cyc;
    int   n_pass;
    int   n_total;

    typedef struct {
        int val;
        int ovf;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   model_val;
    int   model_ovf;

    dcm_ps_responder_if #(.PS_W(W)) ifc ();

    dcm_ps_responder #(.PS_LATENCY(L), .PS_MAX(PMAX), .PS_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .ps  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Scoreboard model: the expected result of each accepted request
    task automatic push_req(input logic dir);
        exp_t e;
        if (dir && model_val < PMAX) begin
            model_val++;
            model_ovf = 0;
        end else if (!dir && model_val > -PMAX) begin
            model_val--;
            model_ovf = 0;
        end else begin
            model_ovf = 1;
        end
        e.val = model_val;
        e.ovf = model_ovf;
        e.at  = cyc + L;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && ifc.psdone) begin
            if (exp_q.size() == 0) begin
                check("unexpected_psdone", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("psdone_cycle", cyc, e.at);
                check("ps_value", int'($signed(ifc.ps_value)), e.val);
                check("ps_ovf", int'(ifc.ps_ovf), e.ovf);
            end
        end
    end

    task automatic issue(input logic dir);
        @(posedge clk); #1;
        ifc.psen     = 1'b1;
        ifc.psincdec = dir;
        push_req(dir);
        @(posedge clk); #1;
        ifc.psen = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        bit seen;
        seen = 0;
        busy_cycles = 0;
        for (int i = 0; i < L + 10 && !seen; i++) begin
            @(negedge clk);
            if (ifc.busy) busy_cycles++;
            if (ifc.psdone) seen = 1;
        end
        if (!seen) check("psdone_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        model_val = 0;
        model_ovf = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_psdone"}, int'(ifc.psdone), 0);
        check({tag, "_value"}, int'($signed(ifc.ps_value)), 0);
        check({tag, "_ovf"}, int'(ifc.ps_ovf), 0);
        check({tag, "_busy"}, int'(ifc.busy), 0);
        check({tag, "_err"}, int'(ifc.ps_err), 0);
    endtask

    initial begin
        int bc;
        int dones;
        n_pass = 0;
        n_total = 0;
        model_val = 0;
        model_ovf = 0;
        rst = 1'b1;
        ifc.psen = 1'b0;
        ifc.psincdec = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_all_zero("reset");

        // Single increment: latency, busy width, value 0 -> 1
        issue(1'b1);
        wait_done(bc);
        check("busy_cycles", bc, L);
        @(negedge clk);
        check("busy_after_done", int'(ifc.busy), 0);
        check("psdone_width", int'(ifc.psdone), 0);

        // 300 increments, each issued the cycle after psdone
        do_reset();
        for (int i = 0; i < 300; i++) begin
            issue(1'b1);
            wait_done(bc);
        end
        check("sat_hi_value", int'($signed(ifc.ps_value)), 255);
        check("sat_hi_ovf", int'(ifc.ps_ovf), 1);
        issue(1'b0);
        wait_done(bc);
        check("after_hi_dec_value", int'($signed(ifc.ps_value)), 254);
        check("after_hi_dec_ovf", int'(ifc.ps_ovf), 0);

        // Mirror: 300 decrements floor at -255 without wrapping
        do_reset();
        for (int i = 0; i < 300; i++) begin
            issue(1'b0);
            wait_done(bc);
        end
        check("sat_lo_raw", int'(ifc.ps_value), 'h101);
        check("sat_lo_ovf", int'(ifc.ps_ovf), 1);
        issue(1'b1);
        wait_done(bc);
        check("after_lo_inc_value", int'($signed(ifc.ps_value)), -254);

        // psen held for 3 cycles: one request, sticky ps_err
        do_reset();
        @(posedge clk); #1;
        ifc.psen = 1'b1;
        ifc.psincdec = 1'b1;
        push_req(1'b1);
        repeat (3) @(posedge clk);
        #1 ifc.psen = 1'b0;
        check("err_set", int'(ifc.ps_err), 1);
        wait_done(bc);
        issue(1'b1);
        wait_done(bc);
        check("err_sticky", int'(ifc.ps_err), 1);
        do_reset();
        check("err_cleared", int'(ifc.ps_err), 0);

        // Back-to-back: psen raised during the psdone cycle
        issue(1'b1);
        wait_done(bc);
        ifc.psen = 1'b1;
        ifc.psincdec = 1'b1;
        push_req(1'b1);
        @(posedge clk); #1;
        ifc.psen = 1'b0;
        wait_done(bc);
        check("b2b_value", int'($signed(ifc.ps_value)), 2);
        check("b2b_err", int'(ifc.ps_err), 0);

        // Reset mid-request discards it
        do_reset();
        issue(1'b1);
        repeat (2) @(posedge clk);
        do_reset();
        check_all_zero("midrst");
        dones = 0;
        for (int i = 0; i < L + 6; i++) begin
            @(negedge clk);
            if (ifc.psdone) dones++;
        end
        check("midrst_no_done", dones, 0);
        issue(1'b0);
        wait_done(bc);
        @(negedge clk);
        check("post_rst_value", int'($signed(ifc.ps_value)), -1);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
